ps2_host_tx: RTL and testbench



---
 rtl/ps2_host_tx.sv | 188 ++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibits the bus, requests to send, then shifts a byte
// plus odd parity out on the device clock and checks for the device ACK.
module ps2_host_tx #(
  parameter int unsigned INHIBIT_CYCLES = 5000,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       wr,
  input  logic [7:0] wrdata,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe,
  output logic       busy,
  output logic       done,
  output logic       nack
);

  localparam int unsigned CntMax = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES
                                                                     : TIMEOUT_CYCLES;
  localparam int unsigned CntW   = $clog2(CntMax) + 1;
  localparam logic [CntW-1:0] InhLast = CntW'(INHIBIT_CYCLES - 1);
  localparam logic [CntW-1:0] ToLast  = CntW'(TIMEOUT_CYCLES - 1);
  localparam logic [CntW-1:0] CntSat  = '1;

  typedef enum logic [2:0] {
    StIdle, StInhibit, StReq, StSend, StAck, StWaitIdle
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d, cnt_inc;
  logic [3:0]      bitcnt_q, bitcnt_d;
  logic [8:0]      sr_q, sr_d;
  logic            ack_bad_q, ack_bad_d;
  logic            clk_oe_q, clk_oe_d;
  logic            dat_oe_q, dat_oe_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            nack_q, nack_d;

  logic clk_meta_q, clk_sync_q, clk_prev_q;
  logic dat_meta_q, dat_sync_q;
  logic fall, timeout;

  // Sync flops reset high so an idle bus does not look like a falling edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      clk_meta_q <= 1'b1;
      clk_sync_q <= 1'b1;
      clk_prev_q <= 1'b1;
      dat_meta_q <= 1'b1;
      dat_sync_q <= 1'b1;
    end else begin
      clk_meta_q <= ps2_clk_in;
      clk_sync_q <= clk_meta_q;
      clk_prev_q <= clk_sync_q;
      dat_meta_q <= ps2_dat_in;
      dat_sync_q <= dat_meta_q;
    end
  end

  assign fall    = clk_prev_q & ~clk_sync_q;
  assign timeout = (cnt_q == ToLast);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bitcnt_d  = bitcnt_q;
    sr_d      = sr_q;
    ack_bad_d = ack_bad_q;
    clk_oe_d  = 1'b0;
    dat_oe_d  = 1'b0;
    done_d    = 1'b0;
    nack_d    = nack_q;
    cnt_inc   = (cnt_q == CntSat) ? cnt_q : cnt_q + CntW'(1);

    unique case (state_q)
      StIdle: begin
        if (wr && !busy_q) begin
          state_d  = StInhibit;
          cnt_d    = '0;
          bitcnt_d = '0;
          sr_d     = {~^wrdata, wrdata};
          clk_oe_d = 1'b1;
        end
      end
      StInhibit: begin
        clk_oe_d = 1'b1;
        if (cnt_q == InhLast) begin
          state_d  = StReq;
          dat_oe_d = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      StReq: begin
        state_d  = StSend;
        cnt_d    = '0;
        bitcnt_d = '0;
        dat_oe_d = 1'b1;
      end
      StSend: begin
        if (timeout) begin
          state_d = StIdle;
          done_d  = 1'b1;
          nack_d  = 1'b1;
        end else begin
          cnt_d    = cnt_inc;
          dat_oe_d = dat_oe_q;
          if (fall) begin
            // Ones shifted in behind the parity bit become the stop bit.
            dat_oe_d = ~sr_q[0];
            sr_d     = {1'b1, sr_q[8:1]};
            bitcnt_d = bitcnt_q + 4'd1;
            if (bitcnt_q == 4'd9) begin
              state_d = StAck;
            end
          end
        end
      end
      StAck: begin
        if (timeout) begin
          state_d = StIdle;
          done_d  = 1'b1;
          nack_d  = 1'b1;
        end else begin
          cnt_d = cnt_inc;
          if (fall) begin
            ack_bad_d = dat_sync_q;
            state_d   = StWaitIdle;
          end
        end
      end
      StWaitIdle: begin
        if (timeout) begin
          state_d = StIdle;
          done_d  = 1'b1;
          nack_d  = 1'b1;
        end else begin
          cnt_d = cnt_inc;
          if (clk_sync_q && dat_sync_q) begin
            state_d = StIdle;
            done_d  = 1'b1;
            nack_d  = ack_bad_q;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // Busy stays up through the done cycle so a wr there is ignored.
    busy_d = (state_d != StIdle) || done_d;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      bitcnt_q  <= '0;
      sr_q      <= '0;
      ack_bad_q <= 1'b0;
      clk_oe_q  <= 1'b0;
      dat_oe_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      nack_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bitcnt_q  <= bitcnt_d;
      sr_q      <= sr_d;
      ack_bad_q <= ack_bad_d;
      clk_oe_q  <= clk_oe_d;
      dat_oe_q  <= dat_oe_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      nack_q    <= nack_d;
    end
  end

  assign ps2_clk_oe = clk_oe_q;
  assign ps2_dat_oe = dat_oe_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign nack       = nack_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-drain bus with a behavioural keyboard model that clocks
// frames in, records the bits it sees and optionally ACKs, withholds ACK or never clocks.
module tb_ps2_host_tx;

  localparam int unsigned Inh  = 8;
  localparam int unsigned To   = 400;
  localparam int unsigned Half = 14;

  logic       clock = 1'b0;
  logic       reset;
  logic       wr;
  logic [7:0] wrdata;
  logic       ps2_clk_in, ps2_dat_in;
  logic       ps2_clk_oe, ps2_dat_oe;
  logic       busy, done, nack;
  logic       dev_clk_low, dev_dat_low;

  int checks    = 0;
  int failures  = 0;
  int done_cnt  = 0;

  // Modes: 0 = ACK, 1 = withhold ACK, 2 = never clock, 3 = reset during d4
  typedef struct {
    logic [7:0]  data;
    int          mode;
    int          hold;
    int          inj;
    logic [10:0] exp_bits;
    logic        exp_nack;
    logic        wr_on_done;
  } vec_t;

  vec_t vecs[6];

  assign ps2_clk_in = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_dat_in = ~(ps2_dat_oe | dev_dat_low);

  always #5 clock = ~clock;

  ps2_host_tx #(
    .INHIBIT_CYCLES(Inh),
    .TIMEOUT_CYCLES(To)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .wr         (wr),
    .wrdata     (wrdata),
    .ps2_clk_in (ps2_clk_in),
    .ps2_dat_in (ps2_dat_in),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_dat_oe (ps2_dat_oe),
    .busy       (busy),
    .done       (done),
    .nack       (nack)
  );

  initial forever begin
    @(posedge clock);
    #2;
    if (done === 1'b1) done_cnt++;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Wire order as the device sees it: start, d0..d7, odd parity, stop.
  function automatic logic [10:0] frame_bits(input logic [7:0] b);
    int          ones;
    logic [10:0] f;
    ones = 0;
    for (int i = 0; i < 8; i++) if (b[i]) ones++;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[i+1] = b[i];
    f[9]  = (ones % 2 == 0);
    f[10] = 1'b1;
    return f;
  endfunction

  task automatic send(input logic [7:0] b, input int mode, input int hold, input int inj,
                      input logic [10:0] exp_bits, input logic exp_nack,
                      input logic wr_on_done);
    int          hold_cnt, dat_cnt, n, d0;
    logic        last_dat, early;
    logic [10:0] seen;
    d0 = done_cnt;
    seen = '0;
    wrdata = b;
    wr = 1'b1;
    tick();
    wr = 1'b0;
    wrdata = 8'h00;
    check("busy_after_wr", 32'(busy), 32'd1);
    check("clk_oe_after_wr", 32'(ps2_clk_oe), 32'd1);

    hold_cnt = 0;
    dat_cnt  = 0;
    last_dat = 1'b0;
    while (ps2_clk_oe && hold_cnt < 100) begin
      hold_cnt++;
      if (ps2_dat_oe) dat_cnt++;
      last_dat = ps2_dat_oe;
      tick();
    end
    check("clk_oe_hold", 32'(hold_cnt), 32'(Inh + 1));
    check("dat_oe_lead_cycles", 32'(dat_cnt), 32'd1);
    check("dat_oe_lead_last", 32'(last_dat), 32'd1);

    if (mode == 2) begin
      n = 0;
      while (!done && n < 2000) begin
        tick();
        n++;
      end
      check("timeout_latency", 32'(n), 32'(To));
      check("timeout_nack", 32'(nack), 32'd1);
      check("timeout_oe", 32'({ps2_clk_oe, ps2_dat_oe}), 32'd0);
    end else begin
      for (int k = 0; k < 11; k++) begin
        if (k == inj) begin
          wrdata = 8'h55;
          wr = 1'b1;
          tick();
          wr = 1'b0;
          repeat (Half - 1) tick();
        end else begin
          repeat (Half) tick();
        end
        seen[k] = ps2_dat_in;
        if (mode == 3 && k == 5) begin
          reset = 1'b1;
          tick();
          reset = 1'b0;
          check("reset_release", 32'({ps2_clk_oe, ps2_dat_oe, busy, done}), 32'd0);
          repeat (5) tick();
          check("reset_no_done", 32'(done_cnt - d0), 32'd0);
          return;
        end
        if (k == 10 && mode == 0) dev_dat_low = 1'b1;
        repeat (2) tick();
        dev_clk_low = 1'b1;
        repeat (Half) tick();
        dev_clk_low = 1'b0;
      end
      check("frame_bits", 32'(seen), 32'(exp_bits));
      early = 1'b0;
      repeat (hold) begin
        tick();
        early |= done;
      end
      dev_dat_low = 1'b0;
      check("no_done_while_dat_low", 32'(early), 32'd0);
      n = 0;
      while (!done && n < 50) begin
        tick();
        n++;
      end
      check("done_seen", 32'(done), 32'd1);
      check("ack_nack", 32'(nack), 32'(exp_nack));
    end

    if (wr_on_done) begin
      wrdata = 8'hA5;
      wr = 1'b1;
    end
    tick();
    wr = 1'b0;
    wrdata = 8'h00;
    check("busy_after_done", 32'(busy), 32'd0);
    check("done_width", 32'(done), 32'd0);
    check("nack_hold", 32'(nack), 32'(exp_nack));
    check("done_count", 32'(done_cnt - d0), 32'd1);
    if (wr_on_done) check("wr_on_done_ignored", 32'(ps2_clk_oe), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] rb;
    int         rmode, rhold;

    vecs[0] = '{8'hF4, 0, 0,  -1, {1'b1, 1'b0, 8'hF4, 1'b0}, 1'b0, 1'b0};
    vecs[1] = '{8'hED, 0, 0,  -1, {1'b1, 1'b1, 8'hED, 1'b0}, 1'b0, 1'b1};
    vecs[2] = '{8'hFF, 1, 0,  -1, {1'b1, 1'b1, 8'hFF, 1'b0}, 1'b1, 1'b0};
    vecs[3] = '{8'h3C, 2, 0,  -1, 11'h000,                   1'b1, 1'b0};
    vecs[4] = '{8'hF4, 0, 0,   3, {1'b1, 1'b0, 8'hF4, 1'b0}, 1'b0, 1'b0};
    vecs[5] = '{8'hAA, 0, 50, -1, {1'b1, 1'b1, 8'hAA, 1'b0}, 1'b0, 1'b0};

    reset = 1'b1;
    wr = 1'b0;
    wrdata = 8'h00;
    dev_clk_low = 1'b0;
    dev_dat_low = 1'b0;
    repeat (3) tick();
    check("reset_outputs", 32'({ps2_clk_oe, ps2_dat_oe, busy, done, nack}), 32'd0);
    reset = 1'b0;
    tick();
    check("idle_outputs", 32'({ps2_clk_oe, ps2_dat_oe, busy, done}), 32'd0);

    for (int i = 0; i < 6; i++) begin
      send(vecs[i].data, vecs[i].mode, vecs[i].hold, vecs[i].inj, vecs[i].exp_bits,
           vecs[i].exp_nack, vecs[i].wr_on_done);
      repeat (3) tick();
    end

    // Reset in the middle of a frame, then a clean 0x00 send.
    send(8'h5A, 3, 0, -1, frame_bits(8'h5A), 1'b0, 1'b0);
    send(8'h00, 0, 0, -1, {1'b1, 1'b1, 8'h00, 1'b0}, 1'b0, 1'b0);
    repeat (3) tick();

    for (int r = 0; r < 6; r++) begin
      rb    = 8'($urandom);
      rmode = int'($urandom_range(0, 1));
      rhold = (rmode == 0) ? int'($urandom_range(0, 30)) : 0;
      send(rb, rmode, rhold, -1, frame_bits(rb), rmode != 0, 1'b0);
      repeat (2) tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
